// File: rtl/fetch_pkg.sv
// fetch_controller shared types.
// State encoding and the instruction word size in bytes.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    HALT
  } state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

endpackage

// File: rtl/fetch_controller_if.sv
// Memory, redirect and decode-slot signals of fetch_controller.
// master = controller side, slave = memory/decode/branch side.
interface fetch_controller_if;

  logic [31:0] mem_addr;
  logic [31:0] mem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  modport master (
    output mem_addr,
    input  mem_instr,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  mem_addr,
    output mem_instr,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_slot.sv
// One-entry instruction slot toward decode.
// Flush beats load; an accepted entry empties unless reloaded.
module fetch_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic        i_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;

  // slot register: flush, load, drain-on-accept, else hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: PC, redirect and end-of-image halt.
// Define FETCH_ALIGN_CHECK_EN to treat misaligned targets as errors.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int          NUM_INSTRUCTIONS = 13,
  parameter logic [31:0] RESET_PC         = 32'd0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  start,
  fetch_controller_if.master bus,
  output logic  busy,
  output logic  done,
  output logic  error
);

  localparam logic [31:0] LIMIT =
    32'(NUM_INSTRUCTIONS) * INSTR_BYTES;
  localparam logic [31:0] LAST = LIMIT - INSTR_BYTES;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic        r_done;
  logic        w_done_nxt;
  logic        r_error;
  logic        w_error_nxt;
  logic        w_load;
  logic        w_flush;
  logic        w_slot_free;
  logic        w_active;
  logic        w_bad_tgt;
  logic [31:0] w_tgt;

  assign w_slot_free = !bus.out_valid || bus.out_ready;
  assign w_active    = (r_state == FETCH) ||
                       (r_state == DRAIN);

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_tgt     = bus.redirect_target;
  assign w_bad_tgt = (bus.redirect_target >= LIMIT) ||
                     (bus.redirect_target[1:0] != 2'b00);
`else
  assign w_tgt     = {bus.redirect_target[31:2], 2'b00};
  assign w_bad_tgt = bus.redirect_target >= LIMIT;
`endif

  // state, PC and sticky status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_done  <= w_done_nxt;
      r_error <= w_error_nxt;
    end
  end

  // next state; a redirect outranks fetch and drain
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_done_nxt  = r_done;
    w_error_nxt = r_error;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    if (w_active && bus.redirect_valid) begin
      w_flush = 1'b1;
      if (w_bad_tgt) begin
        w_error_nxt = 1'b1;
        w_state_nxt = HALT;
      end else begin
        w_pc_nxt    = w_tgt;
        w_state_nxt = FETCH;
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) w_state_nxt = FETCH;
        end
        FETCH: begin
          if (w_slot_free) begin
            w_load = 1'b1;
            if (r_pc == LAST) w_state_nxt = DRAIN;
            else w_pc_nxt = r_pc + INSTR_BYTES;
          end
        end
        DRAIN: begin
          if (w_slot_free) begin
            w_flush     = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = HALT;
          end
        end
        HALT: begin
          w_state_nxt = HALT;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  fetch_slot u_slot (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_ready (bus.out_ready),
    .i_instr (bus.mem_instr),
    .i_pc    (r_pc),
    .o_valid (bus.out_valid),
    .o_instr (bus.out_instr),
    .o_pc    (bus.out_pc)
  );

  assign bus.mem_addr = r_pc;
  assign busy         = w_active;
  assign done         = r_done;
  assign error        = r_error;

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the word-addressed instruction memory. Owns the program counter and drives the memory's byte address. Captures each returned instruction into a one-entry output slot with a valid/ready handshake toward decode. Handles branch/jump redirects and halts cleanly at the end of the program image.

## Interface
- NUM_INSTRUCTIONS, 13, number of 32-bit words in the program image; last valid byte address is NUM_INSTRUCTIONS*4-4
- RESET_PC, 0, byte address loaded into the PC on reset (multiple of 4)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  begin fetching; sampled only in IDLE
- mem_addr  out  32  byte address to instruction memory; combinational copy of PC
- mem_instr  in  32  instruction word returned combinationally by memory for mem_addr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  32  byte address of next instruction
- out_valid  out  1  output slot holds an instruction
- out_instr  out  32  instruction word in slot
- out_pc  out  32  byte address of out_instr
- out_ready  in  1  decode accepts slot this cycle
- busy  out  1  state is FETCH or DRAIN
- done  out  1  normal end of program reached; sticky until reset
- error  out  1  illegal redirect; sticky until reset

## Operation
- States: IDLE, FETCH, DRAIN, HALT. Reset: state IDLE, PC=RESET_PC, out_valid=0, out_instr=0, out_pc=0, done=0, error=0, busy=0.
- Slot free = !out_valid || out_ready.
- IDLE: start=1 -> FETCH. All other inputs ignored.
- FETCH, no redirect, slot free: out_instr<=mem_instr, out_pc<=PC, out_valid<=1. If PC == NUM_INSTRUCTIONS*4-4 -> DRAIN, PC unchanged. Else PC<=PC+4.
- FETCH, no redirect, slot full, out_ready=0: hold everything (stall).
- DRAIN: no further fetch. When out_valid && out_ready, or out_valid=0: out_valid<=0, done<=1 -> HALT.
- Redirect (FETCH or DRAIN) has priority over fetch and drain. out_valid<=0, flushing the wrong-path slot. A same-cycle out_ready handshake still counts as accepted by decode. No fetch that cycle. PC<=redirect_target. State -> FETCH.
- Redirect with redirect_target >= NUM_INSTRUCTIONS*4: out_valid<=0, error<=1 -> HALT, PC unchanged.
- Redirect in IDLE or HALT: ignored.
- HALT: terminal until reset; start ignored; out_valid=0.
- PC arithmetic is 32-bit unsigned. Range checks compare the full 32 bits.

## Timing
- mem_addr = PC with zero latency; memory read is combinational within the cycle.
- Start latency: start sampled at edge N. First instruction valid after edge N+1 with out_pc=RESET_PC.
- Throughput: one instruction per cycle while out_ready=1.
- Redirect latency: redirect sampled at edge M. Slot empty after M. Target instruction valid after edge M+1. Exactly one bubble.
- out_instr/out_pc stable while out_valid=1 and out_ready=0.
- done/error assert on the edge that enters HALT. busy deasserts on that same edge.
- Reset asserted mid-operation returns all state to reset values immediately, without waiting for clk.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: redirect_target[1:0] != 0 is illegal. Handled exactly like an out-of-range target: out_valid<=0, error<=1, HALT.
- Not defined: redirect_target[1:0] is forced to 0 and fetching continues. error is driven only by the range check.

## Structure
- Package fetch_pkg: state enum typedef (IDLE, FETCH, DRAIN, HALT) and constant INSTR_BYTES=4.
- Sub-module fetch_slot: one-entry output register with valid/ready, load, flush and hold. The controller FSM and PC stay in fetch_controller.

## Test plan
- Reset then start, out_ready=1, NUM_INSTRUCTIONS=13 -> out_pc 0,4,...,48 on consecutive cycles. Then done=1, busy=0, out_valid=0.
- out_ready=0 for 3 cycles while out_pc=8 -> out_instr and out_pc held, mem_addr=12 held. Resumes at 12 with no loss or duplication.
- Redirect to 0x20 while slot holds out_pc=0x0C -> slot flushed, next cycle out_valid=0, following cycle out_pc=0x20.
- Redirect in DRAIN (PC=48) to 0x04 -> returns to FETCH, out_pc=0x04 appears, done stays 0.
- Redirect to 0x34 (=13*4) -> error=1, HALT, no further out_valid. With FETCH_ALIGN_CHECK_EN, target 0x06 -> error=1. Without it, target 0x06 -> out_pc=0x04.
- reset asserted asynchronously mid-FETCH at PC=20 -> out_valid=0, PC=RESET_PC, state IDLE before the next clk edge. Later start restarts from 0.
